// File: rtl/timer_core.sv
// Timing engine: derives 1us/1ms/1s timebase pulses from mclk and runs three
// independent periodic 16-bit down-counters, each pulsing an interrupt on expiry.
module timer_core #(
   parameter int US_PER_MS = 1000,
   parameter int MS_PER_S  = 1000
) (
   input  logic        mclk,
   input  logic        h_reset,
   input  logic [9:0]  cfg_pulse_1us,
   input  logic [2:0]  cfg_timer_update,
   input  logic [18:0] cfg_timer0,
   input  logic [18:0] cfg_timer1,
   input  logic [18:0] cfg_timer2,
   output logic        tick_1us,
   output logic        tick_1ms,
   output logic        tick_1s,
   output logic [2:0]  timer_intr,
   output logic [15:0] timer0_cnt,
   output logic [15:0] timer1_cnt,
   output logic [15:0] timer2_cnt
);

   localparam logic [9:0] US_LAST = 10'(US_PER_MS - 1);
   localparam logic [9:0] MS_LAST = 10'(MS_PER_S - 1);

   logic [9:0]  pre_q, pre_d;
   logic [9:0]  us_div_q, us_div_d;
   logic [9:0]  ms_div_q, ms_div_d;
   logic        tick_us_q, tick_us_d;
   logic        tick_ms_q, tick_ms_d;
   logic        tick_s_q, tick_s_d;
   logic [15:0] cnt_q [3];
   logic [15:0] cnt_d [3];
   logic [2:0]  intr_q, intr_d;
   logic [2:0]  sel_tick;
   logic [18:0] cfg [3];

   assign cfg[0] = cfg_timer0;
   assign cfg[1] = cfg_timer1;
   assign cfg[2] = cfg_timer2;

   // Equality-only match: lowering the config below the live count wraps through 1023.
   always_comb begin
      tick_us_d = (pre_q == cfg_pulse_1us);
      pre_d     = tick_us_d ? 10'd0 : pre_q + 10'd1;

      tick_ms_d = tick_us_d && (us_div_q == US_LAST);
      us_div_d  = us_div_q;
      if (tick_us_d) begin
         us_div_d = (us_div_q == US_LAST) ? 10'd0 : us_div_q + 10'd1;
      end

      tick_s_d = tick_ms_d && (ms_div_q == MS_LAST);
      ms_div_d = ms_div_q;
      if (tick_ms_d) begin
         ms_div_d = (ms_div_q == MS_LAST) ? 10'd0 : ms_div_q + 10'd1;
      end
   end

   // Update pulse beats the tick; an expiring tick reloads and raises intr next cycle.
   always_comb begin
      sel_tick = 3'b000;
      intr_d   = 3'b000;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i];
         case (cfg[i][18:17])
            2'b00:   sel_tick[i] = tick_us_q;
            2'b01:   sel_tick[i] = tick_ms_q;
            2'b10:   sel_tick[i] = tick_s_q;
            default: sel_tick[i] = 1'b0;
         endcase
         if (cfg_timer_update[i]) begin
            cnt_d[i] = cfg[i][15:0];
         end else if (cfg[i][16] && sel_tick[i]) begin
            if (cnt_q[i] == 16'd0) begin
               intr_d[i] = 1'b1;
               cnt_d[i]  = cfg[i][15:0];
            end else begin
               cnt_d[i] = cnt_q[i] - 16'd1;
            end
         end
      end
   end

   always_ff @(posedge mclk) begin
      if (h_reset) begin
         pre_q     <= '0;
         us_div_q  <= '0;
         ms_div_q  <= '0;
         tick_us_q <= 1'b0;
         tick_ms_q <= 1'b0;
         tick_s_q  <= 1'b0;
         intr_q    <= '0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         pre_q     <= pre_d;
         us_div_q  <= us_div_d;
         ms_div_q  <= ms_div_d;
         tick_us_q <= tick_us_d;
         tick_ms_q <= tick_ms_d;
         tick_s_q  <= tick_s_d;
         intr_q    <= intr_d;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign tick_1us   = tick_us_q;
   assign tick_1ms   = tick_ms_q;
   assign tick_1s    = tick_s_q;
   assign timer_intr = intr_q;
   assign timer0_cnt = cnt_q[0];
   assign timer1_cnt = cnt_q[1];
   assign timer2_cnt = cnt_q[2];

endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core with short divider ratios (4 us/ms, 3 ms/s);
// outputs are sampled and inputs driven on the falling edge.
module tb_timer_core;

   logic        mclk = 1'b0;
   logic        h_reset;
   logic [9:0]  cfg_pulse_1us;
   logic [2:0]  cfg_timer_update;
   logic [18:0] cfg_timer0, cfg_timer1, cfg_timer2;
   logic        tick_1us, tick_1ms, tick_1s;
   logic [2:0]  timer_intr;
   logic [15:0] timer0_cnt, timer1_cnt, timer2_cnt;

   int checks = 0;
   int errors = 0;

   always #5 mclk = ~mclk;

   timer_core #(.US_PER_MS(4), .MS_PER_S(3)) dut (
      .mclk             (mclk),
      .h_reset          (h_reset),
      .cfg_pulse_1us    (cfg_pulse_1us),
      .cfg_timer_update (cfg_timer_update),
      .cfg_timer0       (cfg_timer0),
      .cfg_timer1       (cfg_timer1),
      .cfg_timer2       (cfg_timer2),
      .tick_1us         (tick_1us),
      .tick_1ms         (tick_1ms),
      .tick_1s          (tick_1s),
      .timer_intr       (timer_intr),
      .timer0_cnt       (timer0_cnt),
      .timer1_cnt       (timer1_cnt),
      .timer2_cnt       (timer2_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return tick_1us;
         1:       return tick_1ms;
         2:       return tick_1s;
         3:       return timer_intr[0];
         4:       return timer_intr[1];
         default: return timer_intr[2];
      endcase
   endfunction

   // Returns once tick_1us is high in the current cycle (bounded).
   task automatic wait_tick_us();
      int b = 0;
      while (!tick_1us && b < 100) begin
         @(negedge mclk);
         b++;
      end
      chk("tick_wait", 32'(tick_1us), 32'd1);
   endtask

   // Cycles from one rising pulse of the selected signal to the next.
   task automatic gap(input int which, output int n);
      int b = 0;
      while (!sig(which) && b < 2000) begin
         @(negedge mclk);
         b++;
      end
      n = 0;
      do begin
         @(negedge mclk);
         n++;
      end while (!sig(which) && n < 2000);
   endtask

   // Number of tick_1us pulses seen before timer_intr[idx] rises.
   task automatic ticks_until_intr(input int idx, output int n);
      int b = 0;
      n = 0;
      while (!timer_intr[idx] && b < 2000) begin
         if (tick_1us) n++;
         @(negedge mclk);
         b++;
      end
      if (b >= 2000) n = -1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int b;
      int ticks;
      logic seen;
      int exp_seq [4] = '{2, 1, 0, 3};

      h_reset          = 1'b1;
      cfg_pulse_1us    = 10'd9;
      cfg_timer_update = 3'b000;
      cfg_timer0       = '0;
      cfg_timer1       = '0;
      cfg_timer2       = '0;
      repeat (3) @(negedge mclk);
      chk("rst_ticks", 32'({tick_1us, tick_1ms, tick_1s}), 32'd0);
      chk("rst_intr", 32'(timer_intr), 32'd0);
      chk("rst_cnts", 32'(timer0_cnt | timer1_cnt | timer2_cnt), 32'd0);

      h_reset = 1'b0;
      n = 0;
      do begin
         @(negedge mclk);
         n++;
      end while (!tick_1us && n < 100);
      chk("first_tick_us", 32'(n), 32'd10);

      gap(0, n);
      chk("gap_1us", 32'(n), 32'd10);
      gap(1, n);
      chk("gap_1ms", 32'(n), 32'd40);
      gap(2, n);
      chk("gap_1s", 32'(n), 32'd120);
      chk("ticks_coincident", 32'({tick_1us, tick_1ms, tick_1s}), 32'd7);

      // Prescaler is at 0 on this cycle; lower the match at count 5 -> wrap.
      repeat (5) @(negedge mclk);
      cfg_pulse_1us = 10'd2;
      n = 0;
      do begin
         @(negedge mclk);
         n++;
      end while (!tick_1us && n < 2000);
      chk("prescaler_wrap", 32'(n), 32'd1022);
      cfg_pulse_1us = 10'd9;

      cfg_timer0       = {2'b00, 1'b1, 16'd3};
      cfg_timer_update = 3'b001;
      @(negedge mclk);
      cfg_timer_update = 3'b000;
      chk("t0_load", 32'(timer0_cnt), 32'd3);
      for (int i = 0; i < 4; i++) begin
         wait_tick_us();
         @(negedge mclk);
         chk("t0_cnt_seq", 32'(timer0_cnt), 32'(exp_seq[i]));
         chk("t0_intr_seq", 32'(timer_intr[0]), 32'(i == 3));
      end
      @(negedge mclk);
      chk("t0_intr_width", 32'(timer_intr[0]), 32'd0);
      gap(3, n);
      chk("t0_period", 32'(n), 32'd40);

      cfg_timer1       = {2'b00, 1'b1, 16'd2};
      cfg_timer_update = 3'b010;
      @(negedge mclk);
      cfg_timer_update = 3'b000;
      b = 0;
      while (!(tick_1us && timer1_cnt == 16'd0) && b < 500) begin
         @(negedge mclk);
         b++;
      end
      chk("t1_reach_zero_tick", 32'(timer1_cnt), 32'd0);
      cfg_timer1       = {2'b00, 1'b1, 16'd5};
      cfg_timer_update = 3'b010;
      @(negedge mclk);
      cfg_timer_update = 3'b000;
      chk("t1_collision_no_intr", 32'(timer_intr[1]), 32'd0);
      chk("t1_collision_cnt", 32'(timer1_cnt), 32'd5);
      ticks_until_intr(1, n);
      chk("t1_full_period", 32'(n), 32'd6);

      cfg_timer2       = {2'b00, 1'b1, 16'd10};
      cfg_timer_update = 3'b100;
      @(negedge mclk);
      cfg_timer_update = 3'b000;
      b = 0;
      while (timer2_cnt != 16'd5 && b < 500) begin
         @(negedge mclk);
         b++;
      end
      chk("t2_at_5", 32'(timer2_cnt), 32'd5);
      cfg_timer2[16] = 1'b0;
      seen  = 1'b0;
      ticks = 0;
      b     = 0;
      while (ticks < 20 && b < 1000) begin
         @(negedge mclk);
         if (tick_1us) ticks++;
         if (timer_intr[2]) seen = 1'b1;
         b++;
      end
      chk("t2_frozen_cnt", 32'(timer2_cnt), 32'd5);
      chk("t2_frozen_no_intr", 32'(seen), 32'd0);
      cfg_timer2[16] = 1'b1;
      ticks_until_intr(2, n);
      chk("t2_resume_ticks", 32'(n), 32'd6);
      chk("t2_reload_after_intr", 32'(timer2_cnt), 32'd10);
      cfg_timer2[18:17] = 2'b11;
      seen = 1'b0;
      repeat (40) begin
         @(negedge mclk);
         if (timer_intr[2]) seen = 1'b1;
      end
      chk("t2_sel11_cnt", 32'(timer2_cnt), 32'd10);
      chk("t2_sel11_no_intr", 32'(seen), 32'd0);

      cfg_timer0       = {2'b00, 1'b1, 16'd0};
      cfg_timer1       = {2'b00, 1'b1, 16'd0};
      cfg_timer2       = {2'b00, 1'b1, 16'd0};
      cfg_timer_update = 3'b111;
      @(negedge mclk);
      cfg_timer_update = 3'b000;
      for (int i = 0; i < 3; i++) begin
         wait_tick_us();
         @(negedge mclk);
         chk("all_intr", 32'(timer_intr), 32'd7);
      end

      cfg_timer0       = {2'b00, 1'b1, 16'd50};
      cfg_timer_update = 3'b001;
      @(negedge mclk);
      cfg_timer_update = 3'b000;
      chk("pre_reset_cnt0", 32'(timer0_cnt), 32'd50);
      wait_tick_us();
      h_reset = 1'b1;
      @(negedge mclk);
      chk("midrst_cnt0", 32'(timer0_cnt), 32'd0);
      chk("midrst_ticks", 32'({tick_1us, tick_1ms, tick_1s}), 32'd0);
      chk("midrst_intr", 32'(timer_intr), 32'd0);
      repeat (2) @(negedge mclk);
      h_reset = 1'b0;
      n = 0;
      do begin
         @(negedge mclk);
         n++;
      end while (!tick_1us && n < 100);
      chk("post_rst_tick_us", 32'(n), 32'd10);

      h_reset       = 1'b1;
      cfg_pulse_1us = 10'd0;
      @(negedge mclk);
      h_reset = 1'b0;
      n = 0;
      repeat (5) begin
         @(negedge mclk);
         if (tick_1us) n++;
      end
      chk("pulse0_every_cycle", 32'(n), 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
